// File: rtl/ssd_scan_decoder_if.sv
// Seven-segment scan bus plus the decoded read-back outputs.
// The master modport is the display/stimulus side; the slave modport is the decoder.
interface ssd_scan_decoder_if #(
  parameter int unsigned NDIG = 4
);
  logic [6:0]        seg;
  logic [NDIG-1:0]   an;
  logic [4*NDIG-1:0] digits;
  logic              frame_valid;
  logic              decode_err;
  logic              an_err;

  modport master (
    output seg, an,
    input  digits, frame_valid, decode_err, an_err
  );

  modport slave (
    input  seg, an,
    output digits, frame_valid, decode_err, an_err
  );
endinterface

// File: rtl/ssd_scan_decoder.sv
// Recovers 4-bit digit codes from a multiplexed active-low seven-segment bus.
// A digit is captured after its pattern is stable; a full frame is published atomically.
module ssd_scan_decoder #(
  parameter int unsigned NDIG          = 4,
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  ssd_scan_decoder_if.slave   bus
);
  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

  state_t                 state_q, state_d;
  logic [NDIG-1:0]        s_an;
  logic [6:0]             s_seg;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NDIG-1:0]        seen_q, seen_d;
  logic [NDIG-1:0][3:0]   shadow_q, shadow_d;
  logic [4*NDIG-1:0]      digits_q, digits_d;
  logic                   frame_valid_q, frame_valid_d;
  logic                   decode_err_q, decode_err_d;
  logic                   an_err_q;

  logic [NDIG-1:0]        low_c;
  logic                   onehot_c;
  logic                   multi_low_c;
  logic                   match_c;
  logic                   capture_c;
  logic [3:0]             code_c;

  function automatic logic [3:0] seg_decode(input logic [6:0] s);
    case (s)
      7'b0000001: seg_decode = 4'd0;
      7'b1001111: seg_decode = 4'd1;
      7'b0010010: seg_decode = 4'd2;
      7'b0000110: seg_decode = 4'd3;
      7'b1001100: seg_decode = 4'd4;
      7'b0100100: seg_decode = 4'd5;
      7'b0100000: seg_decode = 4'd6;
      7'b0001111: seg_decode = 4'd7;
      7'b0000000: seg_decode = 4'd8;
      7'b0000100: seg_decode = 4'd9;
      7'b1111110: seg_decode = 4'd10;
      7'b1111111: seg_decode = 4'd11;
      default:    seg_decode = 4'd15;
    endcase
  endfunction

  // Anode qualification: exactly one low bit selects a digit; more than one is a bus fault
  always_comb begin
    low_c       = ~bus.an;
    multi_low_c = (low_c & (low_c - NDIG'(1))) != '0;
    onehot_c    = (low_c != '0) && !multi_low_c;
    match_c     = (bus.an == s_an) && (bus.seg == s_seg);
    code_c      = seg_decode(bus.seg);
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    seen_d        = seen_q;
    shadow_d      = shadow_q;
    digits_d      = digits_q;
    frame_valid_d = 1'b0;
    decode_err_d  = 1'b0;
    capture_c     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (onehot_c) state_d = TRACK;
      end
      TRACK: begin
        if (!onehot_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!match_c) begin
          cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
          capture_c = 1'b1;
          state_d   = LOCKED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LOCKED: begin
        if (!onehot_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!match_c) begin
          state_d = TRACK;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Capture merges the new digit into the shadow frame; the last missing digit publishes it
    if (capture_c) begin
      for (int i = 0; i < int'(NDIG); i++) begin
        if (low_c[i]) shadow_d[i] = code_c;
      end
      decode_err_d = (code_c == 4'hF);
      if ((seen_q | low_c) == {NDIG{1'b1}}) begin
        digits_d      = shadow_d;
        frame_valid_d = 1'b1;
        seen_d        = '0;
      end else begin
        seen_d = seen_q | low_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      s_an          <= '1;
      s_seg         <= '1;
      cnt_q         <= '0;
      seen_q        <= '0;
      shadow_q      <= '0;
      digits_q      <= '0;
      frame_valid_q <= 1'b0;
      decode_err_q  <= 1'b0;
      an_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      s_an          <= bus.an;
      s_seg         <= bus.seg;
      cnt_q         <= cnt_d;
      seen_q        <= seen_d;
      shadow_q      <= shadow_d;
      digits_q      <= digits_d;
      frame_valid_q <= frame_valid_d;
      decode_err_q  <= decode_err_d;
      an_err_q      <= multi_low_c;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.decode_err  = decode_err_q;
  assign bus.an_err      = an_err_q;
endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Bench for ssd_scan_decoder: directed vector table, hand-written timing corners,
// and randomized scans checked every cycle against a run-length reference model.
module tb_ssd_scan_decoder;
  localparam int S = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ssd_scan_decoder_if #(.NDIG(4)) bus ();

  ssd_scan_decoder #(.NDIG(4), .STABLE_CYCLES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          rst;
    logic [3:0]  an;
    logic [6:0]  seg;
    int          hold;
    int          exp_fv;
    int          exp_de;
    int          exp_ae;
    logic [15:0] exp_dig;
  } vec_t;

  vec_t vt[27];
  int n_cmp = 0;
  int n_bad = 0;
  int fv_cnt, de_cnt, ae_cnt;

  logic [6:0] pat_tab [12] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b1111110, 7'b1111111};

  // Reference model: a digit is captured when the same one-hot (an,seg) pair has been
  // present on S+1 consecutive edges; exactly once per unbroken run.
  logic [3:0]  m_prev_an;
  logic [6:0]  m_prev_seg;
  int          m_run;
  logic [3:0]  m_seen;
  logic [3:0]  m_shadow [4];
  logic [15:0] m_digits;
  logic        m_fv, m_de, m_ae;

  function automatic logic [3:0] ref_code(input logic [6:0] s);
    ref_code = 4'hF;
    for (int k = 0; k < 12; k++) if (pat_tab[k] == s) ref_code = 4'(k);
  endfunction

  task automatic model_reset();
    m_prev_an = 4'hF; m_prev_seg = 7'h7F; m_run = 0; m_seen = 4'h0;
    for (int i = 0; i < 4; i++) m_shadow[i] = 4'h0;
    m_digits = 16'h0; m_fv = 1'b0; m_de = 1'b0; m_ae = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] a, input logic [6:0] s);
    int lows;
    logic [3:0] code;
    lows = $countones(~a);
    m_fv = 1'b0; m_de = 1'b0;
    m_ae = (lows > 1);
    if (lows == 1 && m_run > 0 && a == m_prev_an && s == m_prev_seg) m_run++;
    else if (lows == 1) m_run = 1;
    else m_run = 0;
    m_prev_an = a; m_prev_seg = s;
    if (m_run == S + 1) begin
      code = ref_code(s);
      m_de = (code == 4'hF);
      for (int i = 0; i < 4; i++) if (!a[i]) begin m_shadow[i] = code; m_seen[i] = 1'b1; end
      if (m_seen == 4'hF) begin
        m_digits = {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
        m_fv = 1'b1; m_seen = 4'h0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic [3:0] a, input logic [6:0] s);
    bus.an = a; bus.seg = s;
    @(posedge clk);
    model_edge(a, s);
    @(negedge clk);
    fv_cnt += int'(bus.frame_valid);
    de_cnt += int'(bus.decode_err);
    ae_cnt += int'(bus.an_err);
    check("cycle_outputs", {13'h0, bus.digits, bus.frame_valid, bus.decode_err, bus.an_err},
          {13'h0, m_digits, m_fv, m_de, m_ae});
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus.an = 4'hF; bus.seg = 7'h7F;
    repeat (2) @(negedge clk);
    check("rst_digits", 32'(bus.digits), 32'h0);
    check("rst_flags", {29'h0, bus.frame_valid, bus.decode_err, bus.an_err}, 32'h0);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic capture_digit(input logic [3:0] a, input logic [6:0] s);
    repeat (20) cycle(a, s);
  endtask

  initial begin
    int lat;
    logic [3:0] ra;
    logic [6:0] rs;
    int rh;

    // rst, an, seg, hold, frames, decode errs, an errs, digits after row
    vt[0]  = '{1'b1, 4'b1110, 7'b0000110,  20, 0, 0, 0, 16'h0000};
    vt[1]  = '{1'b0, 4'b1101, 7'b1001111,  20, 0, 0, 0, 16'h0000};
    vt[2]  = '{1'b0, 4'b1011, 7'b1001100,  20, 0, 0, 0, 16'h0000};
    vt[3]  = '{1'b0, 4'b0111, 7'b1111110,  20, 1, 0, 0, 16'hA413};
    vt[4]  = '{1'b1, 4'b1110, 7'b0010010,  S-1, 0, 0, 0, 16'h0000};
    vt[5]  = '{1'b0, 4'b1111, 7'b1111111,   5, 0, 0, 0, 16'h0000};
    vt[6]  = '{1'b0, 4'b1101, 7'b1001111,  20, 0, 0, 0, 16'h0000};
    vt[7]  = '{1'b0, 4'b1011, 7'b0000000,  20, 0, 0, 0, 16'h0000};
    vt[8]  = '{1'b0, 4'b0111, 7'b1111111,  20, 0, 0, 0, 16'h0000};
    vt[9]  = '{1'b0, 4'b1110, 7'b0010010,  20, 1, 0, 0, 16'hB812};
    vt[10] = '{1'b0, 4'b1011, 7'b1010101,  20, 0, 1, 0, 16'hB812};
    vt[11] = '{1'b0, 4'b1110, 7'b0100100,  20, 0, 0, 0, 16'hB812};
    vt[12] = '{1'b0, 4'b1101, 7'b0100000,  20, 0, 0, 0, 16'hB812};
    vt[13] = '{1'b0, 4'b0111, 7'b0001111,  20, 1, 0, 0, 16'h7F65};
    vt[14] = '{1'b0, 4'b1100, 7'b0000000,   5, 0, 0, 5, 16'h7F65};
    vt[15] = '{1'b0, 4'b1111, 7'b1111111,   3, 0, 0, 0, 16'h7F65};
    vt[16] = '{1'b0, 4'b1101, 7'b0000110, 100, 0, 0, 0, 16'h7F65};
    vt[17] = '{1'b0, 4'b1110, 7'b0000000,  20, 0, 0, 0, 16'h7F65};
    vt[18] = '{1'b0, 4'b1011, 7'b1111111,  20, 0, 0, 0, 16'h7F65};
    vt[19] = '{1'b0, 4'b0111, 7'b0000001,  20, 1, 0, 0, 16'h0B38};
    vt[20] = '{1'b1, 4'b1110, 7'b1001111,  20, 0, 0, 0, 16'h0000};
    vt[21] = '{1'b0, 4'b1101, 7'b1001111,  20, 0, 0, 0, 16'h0000};
    vt[22] = '{1'b0, 4'b1011, 7'b1001111,  20, 0, 0, 0, 16'h0000};
    vt[23] = '{1'b1, 4'b0111, 7'b0000001,  20, 0, 0, 0, 16'h0000};
    vt[24] = '{1'b0, 4'b1110, 7'b1001111,  20, 0, 0, 0, 16'h0000};
    vt[25] = '{1'b0, 4'b1101, 7'b1001111,  20, 0, 0, 0, 16'h0000};
    vt[26] = '{1'b0, 4'b1011, 7'b1001111,  20, 1, 0, 0, 16'h0111};

    bus.an = 4'hF; bus.seg = 7'h7F;
    model_reset();
    for (int r = 0; r < 27; r++) begin
      if (vt[r].rst) do_reset();
      fv_cnt = 0; de_cnt = 0; ae_cnt = 0;
      repeat (vt[r].hold) cycle(vt[r].an, vt[r].seg);
      check($sformatf("row%0d_frames", r), 32'(fv_cnt), 32'(vt[r].exp_fv));
      check($sformatf("row%0d_decode_err", r), 32'(de_cnt), 32'(vt[r].exp_de));
      check($sformatf("row%0d_an_err", r), 32'(ae_cnt), 32'(vt[r].exp_ae));
      check($sformatf("row%0d_digits", r), 32'(bus.digits), 32'(vt[r].exp_dig));
    end

    // Capture latency: last digit held from its first edge, frame_valid seen S+1 samples later
    do_reset();
    capture_digit(4'b1110, 7'b0000001);
    capture_digit(4'b1101, 7'b1001111);
    capture_digit(4'b1011, 7'b0010010);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      cycle(4'b0111, 7'b0000110);
      if (bus.frame_valid) begin lat = k; break; end
    end
    check("latency", 32'(lat), 32'(S + 1));
    check("latency_digits", 32'(bus.digits), 32'h3210);

    // Threshold: S edges of a stable pattern are not enough, S+1 are
    do_reset();
    capture_digit(4'b1101, 7'b1001111);
    capture_digit(4'b1011, 7'b0010010);
    capture_digit(4'b0111, 7'b0000110);
    fv_cnt = 0;
    repeat (S) cycle(4'b1110, 7'b0000100);
    repeat (4) cycle(4'b1111, 7'b1111111);
    check("short_hold_frames", 32'(fv_cnt), 32'h0);
    repeat (S + 1) cycle(4'b1110, 7'b0000100);
    check("full_hold_frames", 32'(fv_cnt), 32'h1);
    check("full_hold_pulse", 32'(bus.frame_valid), 32'h1);
    check("full_hold_digits", 32'(bus.digits), 32'h3219);

    // Randomized scanning with glitches, overlaps and occasional resets
    do_reset();
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: ra = ~(4'b0001 << $urandom_range(0, 3));
        6:                ra = 4'hF;
        default:          ra = 4'($urandom);
      endcase
      if ($urandom_range(0, 4) != 0) rs = pat_tab[$urandom_range(0, 11)];
      else rs = 7'($urandom);
      rh = int'($urandom_range(1, 24));
      if ($urandom_range(0, 99) == 0) do_reset();
      repeat (rh) cycle(ra, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
